clk_bringup_seq: RTL and testbench
==================================

# clk_bringup_seq

Clock bring-up sequencer for the HDMI pixel-clock chain. It runs on the free-running crystal clock and sequences the serial-clock PLL reset, lock qualification and the 270→27 MHz CLKDIV `RESETN` release. Only after all three does it flag the pixel domain ready. It recovers automatically from lock loss with a bounded retry count, and latches a fault once retries are exhausted.

## Interface
Parameters:
- `PLL_RST_CYC`, 16: cycles `pll_reset` is held high per attempt.
- `LOCK_TIMEOUT`, 65536: maximum cycles spent waiting for lock per attempt.
- `LOCK_STABLE_CYC`, 1024: consecutive synchronized-lock cycles required before the divider is released.
- `DIV_SETTLE_CYC`, 32: cycles after `clkdiv_resetn` rises before `ready` asserts.
- `MAX_RETRY`, 3: failed attempts tolerated before entering FAULT.

Ports:
- `clkin` in 1: crystal clock (27 MHz).
- `resetn` in 1: asynchronous, active-low reset.
- `pll_lock` in 1: PLL LOCK, asynchronous to `clkin`.
- `restart` in 1: single-cycle soft restart request.
- `pll_reset` out 1: active-high PLL reset.
- `clkdiv_resetn` out 1: drives CLKDIV `RESETN`.
- `ready` out 1: pixel clock valid; pixel-domain reset may release.
- `fault` out 1: retries exhausted.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: failed attempts since the last RUN entry or restart.
- `state_o` out 3: FSM state for debug.

## Operation
- `pll_lock` passes through a 2-flop synchronizer (reset value 0). Only the synchronized value `lock_s` is used internally.
- States: PLL_RST, WAIT_LOCK, LOCK_STABLE, DIV_SETTLE, RUN, FAULT.
- PLL_RST:
  - `pll_reset`=1, `clkdiv_resetn`=0, `ready`=0.
  - After `PLL_RST_CYC` cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - `pll_reset`=0.
  - If `lock_s`=1, go to LOCK_STABLE with the counter cleared.
  - If the counter reaches `LOCK_TIMEOUT-1` with no lock, take the failure path.
- LOCK_STABLE:
  - `lock_s` must stay 1 for `LOCK_STABLE_CYC` consecutive cycles, then go to DIV_SETTLE.
  - A drop returns to WAIT_LOCK with the counter cleared. This is a glitch, not a failure; no retry increment.
- DIV_SETTLE: `clkdiv_resetn`=1. After `DIV_SETTLE_CYC` cycles, go to RUN.
- RUN:
  - `ready`=1.
  - `retry_cnt` clears on entry.
- Lock loss in DIV_SETTLE or RUN (`lock_s`=0) takes the failure path.
- Failure path:
  - If `retry_cnt`==`MAX_RETRY`, go to FAULT.
  - Otherwise increment `retry_cnt` and go to PLL_RST.
- FAULT:
  - `pll_reset`=1, `clkdiv_resetn`=0, `ready`=0, `fault`=1.
  - Held until `restart` or `resetn`.
- `restart` in any state: go to PLL_RST and clear `retry_cnt` and `fault`.
- `restart` has priority over a simultaneous lock loss or timeout.
- All counters saturate. A single shared counter is sized `$clog2` of the largest parameter.

## Timing
- Reset values: `pll_reset`=1, `clkdiv_resetn`=0, `ready`=0, `fault`=0, `retry_cnt`=0, state=PLL_RST.
- All outputs are registered, decoded from the next state, so each changes on the same edge as the state transition.
- `lock_s` lags `pll_lock` by 2 `clkin` edges.
- With `pll_lock` tied to 1, `ready` rises exactly `PLL_RST_CYC+1+LOCK_STABLE_CYC+DIV_SETTLE_CYC` edges after the first edge following `resetn` release.
- Lock loss in RUN: `ready`=0 and `clkdiv_resetn`=0 on the 3rd edge after `pll_lock` falls (2 sync edges plus 1 registered transition). `pll_reset`=1 on that same edge.
- Mid-operation `resetn` assertion forces the reset values immediately (asynchronous).

## Structure
- Package `clk_bringup_pkg`: state enum (3-bit, explicit encodings PLL_RST=0 … FAULT=5) and the `state_o` encoding.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with asynchronous active-low reset, instantiated for `pll_lock`.

## Test plan
Test parameters: `PLL_RST_CYC`=4, `LOCK_TIMEOUT`=64, `LOCK_STABLE_CYC`=8, `DIV_SETTLE_CYC`=4, `MAX_RETRY`=2.
- Nominal: `pll_lock`=1 constantly → `pll_reset` falls at edge 4, `clkdiv_resetn` rises at edge 13, `ready` rises at edge 17, `retry_cnt`=0.
- Glitch: `pll_lock` low for 3 cycles during LOCK_STABLE → state returns to WAIT_LOCK, `retry_cnt` unchanged, `ready` delayed by the glitch plus a full 8 stable cycles.
- Timeout: `pll_lock`=0 permanently → 3 timeout attempts at 64 cycles each, `retry_cnt` steps 1, 2, then `fault`=1 with `pll_reset`=1.
- Lock loss in RUN: drop `pll_lock` → `ready`/`clkdiv_resetn` fall 3 edges later, `retry_cnt`=1; restore lock → `ready` returns and `retry_cnt` clears to 0.
- Restart from FAULT: pulse `restart` → `fault`=0, `retry_cnt`=0, state PLL_RST on the next edge. `restart` coincident with lock loss in RUN → PLL_RST with `retry_cnt`=0.
- Async reset in DIV_SETTLE: assert `resetn` mid-cycle → all outputs take their reset values before the next `clkin` edge.

Source files
------------

// File: rtl/clk_bringup_pkg.sv
// Shared types for the HDMI pixel-clock bring-up sequencer.
// The state encoding is also the debug encoding presented on state_o.
package clk_bringup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST     = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_STABLE = 3'd2,
    ST_DIV_SETTLE  = 3'd3,
    ST_RUN         = 3'd4,
    ST_FAULT       = 3'd5
  } state_e;

  function automatic logic [STATE_W-1:0] state_code(input state_e s);
    return s;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_bringup_seq_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset (resets to 0).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_bringup_seq.sv
// Pixel-clock chain bring-up: PLL reset, lock qualification, CLKDIV release,
// with automatic retry on lock loss and a latched fault once retries run out.
module clk_bringup_seq
  import clk_bringup_pkg::*;
#(
  parameter int PLL_RST_CYC     = 16,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int DIV_SETTLE_CYC  = 32,
  parameter int MAX_RETRY       = 3
) (
  input  logic                           clkin,
  input  logic                           resetn,
  input  logic                           pll_lock,
  input  logic                           restart,
  output logic                           pll_reset,
  output logic                           clkdiv_resetn,
  output logic                           ready,
  output logic                           fault,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [STATE_W-1:0]             state_o
);

  localparam int MAX_P = max_int(max_int(PLL_RST_CYC, LOCK_TIMEOUT),
                                 max_int(LOCK_STABLE_CYC, DIV_SETTLE_CYC));
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DIV_SETTLE_CYC - 1);
  localparam logic [RTY_W-1:0] C_RTY_MAX  = RTY_W'(MAX_RETRY);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [RTY_W-1:0] r_retry;
  logic [RTY_W-1:0] w_retry_nxt;
  logic             w_lock_s;
  logic             w_fail;

  logic r_pll_reset;
  logic r_clkdiv_resetn;
  logic r_ready;
  logic r_fault;
  logic w_pll_reset_nxt;
  logic w_clkdiv_resetn_nxt;
  logic w_ready_nxt;
  logic w_fault_nxt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk   (clkin),
    .i_rst_n (resetn),
    .i_d     (pll_lock),
    .o_q     (w_lock_s)
  );

  // One shared cycle counter; it is cleared on every state change and saturates.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      r_state         <= ST_PLL_RST;
      r_cnt           <= '0;
      r_retry         <= '0;
      r_pll_reset     <= 1'b1;
      r_clkdiv_resetn <= 1'b0;
      r_ready         <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_retry         <= w_retry_nxt;
      r_pll_reset     <= w_pll_reset_nxt;
      r_clkdiv_resetn <= w_clkdiv_resetn_nxt;
      r_ready         <= w_ready_nxt;
      r_fault         <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_retry_nxt = r_retry;
    w_fail      = 1'b0;
    if (restart) begin
      w_state_nxt = ST_PLL_RST;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt == C_RST_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle itself still counts as success.
          if (w_lock_s) begin
            w_state_nxt = ST_LOCK_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TMO_LAST) begin
            w_fail = 1'b1;
          end
        end
        ST_LOCK_STABLE: begin
          if (!w_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_STB_LAST) begin
            w_state_nxt = ST_DIV_SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_DIV_SETTLE: begin
          if (!w_lock_s) begin
            w_fail = 1'b1;
          end else if (r_cnt == C_DIV_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!w_lock_s) w_fail = 1'b1;
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_fail) begin
        w_cnt_nxt = '0;
        if (r_retry == C_RTY_MAX) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = ST_PLL_RST;
          w_retry_nxt = r_retry + 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they switch with the transition.
  always_comb begin
    w_pll_reset_nxt     = (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAULT);
    w_clkdiv_resetn_nxt = (w_state_nxt == ST_DIV_SETTLE) || (w_state_nxt == ST_RUN);
    w_ready_nxt         = (w_state_nxt == ST_RUN);
    w_fault_nxt         = (w_state_nxt == ST_FAULT);
  end

  assign pll_reset     = r_pll_reset;
  assign clkdiv_resetn = r_clkdiv_resetn;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry;
  assign state_o       = state_code(r_state);

endmodule

// File: tb/tb_clk_bringup_seq.sv
// Self-checking bench for clk_bringup_seq: nominal vector table, hand-written
// corner sequences, and randomized lock-arrival trials against an arithmetic model.
module tb_clk_bringup_seq;

  localparam int P  = 4;
  localparam int T  = 64;
  localparam int S  = 8;
  localparam int D  = 4;
  localparam int MR = 2;

  logic       clkin = 1'b0;
  logic       resetn = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset;
  logic       clkdiv_resetn;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    int          edge_no;
    logic [15:0] exp;
  } vec_t;

  vec_t nom[$];

  clk_bringup_seq #(
    .PLL_RST_CYC     (P),
    .LOCK_TIMEOUT    (T),
    .LOCK_STABLE_CYC (S),
    .DIV_SETTLE_CYC  (D),
    .MAX_RETRY       (MR)
  ) dut (
    .clkin         (clkin),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .restart       (restart),
    .pll_reset     (pll_reset),
    .clkdiv_resetn (clkdiv_resetn),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .state_o       (state_o)
  );

  // clock / reset
  always #5 clkin = ~clkin;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clkin);
    #1;
    edge_n++;
  endtask

  task automatic step_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic apply_reset();
    resetn  = 1'b0;
    restart = 1'b0;
    repeat (2) @(posedge clkin);
    #1;
    resetn = 1'b1;
    edge_n = 0;
  endtask

  // scoreboard helpers
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic logic [15:0] outs();
    return {7'd0, pll_reset, clkdiv_resetn, ready, fault, retry_cnt, state_o};
  endfunction

  function automatic logic [15:0] pack(input int pr, input int cd, input int rd,
                                       input int ft, input int rt, input int st);
    return {7'd0, pr[0], cd[0], rd[0], ft[0], rt[1:0], st[2:0]};
  endfunction

  // Lock becomes visible to the sequencer 3 edges after the drive edge; each
  // attempt is P reset edges then up to T waiting edges.
  function automatic void model(input int lk, output int is_fault, output int ev_e,
                                output int div_e, output int k_o);
    int a;
    int w;
    int s;
    int e;
    a        = 0;
    s        = lk + 3;
    is_fault = 1;
    div_e    = -1;
    k_o      = MR;
    ev_e     = 0;
    for (int k = 0; k <= MR; k++) begin
      w = a + P;
      if (s <= w + T) begin
        e        = (s > w + 1) ? s : w + 1;
        div_e    = e + S;
        ev_e     = e + S + D;
        k_o      = k;
        is_fault = 0;
        return;
      end
      a = w + T;
    end
    ev_e = a;
  endfunction

  initial begin
    // reset values
    #2;
    resetn = 1'b0;
    #1;
    check("reset values", outs(), pack(1, 0, 0, 0, 0, 0));

    // nominal bring-up, lock tied high
    nom.push_back('{edge_no: 1,  exp: pack(1, 0, 0, 0, 0, 0)});
    nom.push_back('{edge_no: 3,  exp: pack(1, 0, 0, 0, 0, 0)});
    nom.push_back('{edge_no: 4,  exp: pack(0, 0, 0, 0, 0, 1)});
    nom.push_back('{edge_no: 5,  exp: pack(0, 0, 0, 0, 0, 2)});
    nom.push_back('{edge_no: 12, exp: pack(0, 0, 0, 0, 0, 2)});
    nom.push_back('{edge_no: 13, exp: pack(0, 1, 0, 0, 0, 3)});
    nom.push_back('{edge_no: 16, exp: pack(0, 1, 0, 0, 0, 3)});
    nom.push_back('{edge_no: 17, exp: pack(0, 1, 1, 0, 0, 4)});
    nom.push_back('{edge_no: 20, exp: pack(0, 1, 1, 0, 0, 4)});
    pll_lock = 1'b1;
    apply_reset();
    for (int i = 0; i < nom.size(); i++) begin
      step_to(nom[i].edge_no);
      check($sformatf("nominal@%0d", nom[i].edge_no), outs(), nom[i].exp);
    end

    // glitch during LOCK_STABLE: lock_s low on edges 10..12
    pll_lock = 1'b1;
    apply_reset();
    step_to(7);
    pll_lock = 1'b0;
    step_to(10);
    check("glitch back to wait", outs(), pack(0, 0, 0, 0, 0, 1));
    pll_lock = 1'b1;
    step_to(24);
    check("glitch ready delayed", outs(), pack(0, 1, 0, 0, 0, 3));
    step_to(25);
    check("glitch ready", outs(), pack(0, 1, 1, 0, 0, 4));

    // timeout path to FAULT
    pll_lock = 1'b0;
    apply_reset();
    step_to(67);
    check("timeout wait0", outs(), pack(0, 0, 0, 0, 0, 1));
    step_to(68);
    check("timeout retry1", outs(), pack(1, 0, 0, 0, 1, 0));
    step_to(72);
    check("timeout wait1", outs(), pack(0, 0, 0, 0, 1, 1));
    step_to(136);
    check("timeout retry2", outs(), pack(1, 0, 0, 0, 2, 0));
    step_to(203);
    check("timeout wait2", outs(), pack(0, 0, 0, 0, 2, 1));
    step_to(204);
    check("timeout fault", outs(), pack(1, 0, 0, 1, 2, 5));
    step_to(230);
    check("fault held", outs(), pack(1, 0, 0, 1, 2, 5));

    // restart from FAULT
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart from fault", outs(), pack(1, 0, 0, 0, 0, 0));

    // lock loss in RUN, then recovery
    pll_lock = 1'b1;
    apply_reset();
    step_to(20);
    pll_lock = 1'b0;
    step_to(22);
    check("run loss before", outs(), pack(0, 1, 1, 0, 0, 4));
    step_to(23);
    check("run loss", outs(), pack(1, 0, 0, 0, 1, 0));
    pll_lock = 1'b1;
    step_to(39);
    check("recover settle", outs(), pack(0, 1, 0, 0, 1, 3));
    step_to(40);
    check("recover run", outs(), pack(0, 1, 1, 0, 0, 4));

    // restart coincident with lock loss in RUN
    pll_lock = 1'b1;
    apply_reset();
    step_to(20);
    pll_lock = 1'b0;
    step_to(22);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart vs loss", outs(), pack(1, 0, 0, 0, 0, 0));

    // asynchronous reset in DIV_SETTLE
    pll_lock = 1'b1;
    apply_reset();
    step_to(14);
    check("div settle", outs(), pack(0, 1, 0, 0, 0, 3));
    #2;
    resetn = 1'b0;
    #1;
    check("async reset", outs(), pack(1, 0, 0, 0, 0, 0));

    // randomized lock arrival
    for (int t = 0; t < 12; t++) begin
      int lk;
      int fz;
      int ee;
      int de;
      int ko;
      int got_ev;
      int got_div;
      int got_rt;
      if (t == 0) lk = 65;
      else if (t == 1) lk = 66;
      else lk = int'($urandom_range(0, 220));
      model(lk, fz, ee, de, ko);
      exp_q.push_back(16'(fz));
      exp_q.push_back(16'(ee));
      exp_q.push_back(16'(de));
      exp_q.push_back(16'(ko));
      pll_lock = 1'b0;
      apply_reset();
      if (lk == 0) pll_lock = 1'b1;
      got_ev  = -1;
      got_div = -1;
      got_rt  = -1;
      while (ready !== 1'b1 && fault !== 1'b1 && edge_n < 400) begin
        step();
        if (edge_n == lk) pll_lock = 1'b1;
        if (clkdiv_resetn === 1'b1 && got_div < 0) begin
          got_div = edge_n;
          got_rt  = int'(retry_cnt);
        end
      end
      if (ready === 1'b1 || fault === 1'b1) got_ev = edge_n;
      if (fault === 1'b1) got_rt = int'(retry_cnt);
      check($sformatf("rnd%0d fault", t), 16'(fault), exp_q.pop_front());
      check($sformatf("rnd%0d event edge", t), 16'(got_ev), exp_q.pop_front());
      check($sformatf("rnd%0d div edge", t), 16'(got_div), exp_q.pop_front());
      check($sformatf("rnd%0d retry", t), 16'(got_rt), exp_q.pop_front());
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
